// File: rtl/jtframe_pll_sup_pkg.sv
// jtframe_pll_sup_pkg: shared state encoding and saturating counter helper for the PLL supervisor
package jtframe_pll_sup_pkg;
  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } state_t;
  // increments v unless it already holds the all-ones value of a w-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    return v == (32'd1 << w) - 32'd1 ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/jtframe_sync.sv
// jtframe_sync: multi-flop synchronizer for a single asynchronous status line
// clk: destination clock, rst: sync active-high clear of the chain
// d: asynchronous input, q: d delayed by STAGES flops
module jtframe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff;
  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/jtframe_pll_sup.sv
// jtframe_pll_sup: drives PLL reset, waits for stable lock, then releases the core reset
// clk/rst: board reference clock and sync active-high reset
// pll_locked: async lock flag, force_relock: restart request, clr_cnt: clear event counters
// pll_rst: PLL reset, sys_rst: core reset, ready: high in RUN
// unlock_cnt/retry_cnt: saturating counts of lock losses in RUN and lock timeouts
module jtframe_pll_sup
  import jtframe_pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PLL_RST_LEN = 32,
  parameter int LOCK_WAIT   = 1024,
  parameter int TIMEOUT     = 50000,
  parameter int CNTW        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pll_locked,
  input  logic            force_relock,
  input  logic            clr_cnt,
  output logic            pll_rst,
  output logic            sys_rst,
  output logic            ready,
  output logic [CNTW-1:0] unlock_cnt,
  output logic [CNTW-1:0] retry_cnt
);
  localparam int M1 = PLL_RST_LEN > LOCK_WAIT ? PLL_RST_LEN : LOCK_WAIT;
  localparam int MAXV = M1 > TIMEOUT ? M1 : TIMEOUT;
  localparam int TW = $clog2(MAXV) + 1;
  localparam logic [TW-1:0] T_RST = TW'(PLL_RST_LEN - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_WAIT - 1);
  localparam logic [TW-1:0] T_OUT = TW'(TIMEOUT - 1);
  state_t st;
  logic [TW-1:0] timer;
  logic locked_s, unlock_ev, retry_ev;
  jtframe_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(pll_locked),
    .q(locked_s)
  );
  // an unlock in RUN counts even when a relock request arrives alongside it,
  // while a forced relock pre-empts a coinciding timeout without counting it
  assign unlock_ev = st == RUN && !locked_s;
  assign retry_ev = st == WAIT_LOCK && !locked_s && timer == T_OUT && !force_relock;
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= RESET_PLL;
      timer      <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      unlock_cnt <= '0;
      retry_cnt  <= '0;
    end else begin
      unlock_cnt <= clr_cnt ? '0 : unlock_ev ? CNTW'(sat_inc(32'(unlock_cnt), CNTW)) : unlock_cnt;
      retry_cnt  <= clr_cnt ? '0 : retry_ev ? CNTW'(sat_inc(32'(retry_cnt), CNTW)) : retry_cnt;
      if (force_relock && st != RESET_PLL) begin
        st      <= RESET_PLL;
        timer   <= '0;
        pll_rst <= 1'b1;
        sys_rst <= 1'b1;
        ready   <= 1'b0;
      end else begin
        case (st)
          RESET_PLL:
            if (timer == T_RST) begin
              st      <= WAIT_LOCK;
              timer   <= '0;
              pll_rst <= 1'b0;
            end else timer <= timer + 1'b1;
          WAIT_LOCK:
            if (locked_s) begin
              st    <= SETTLE;
              timer <= '0;
            end else if (timer == T_OUT) begin
              st      <= RESET_PLL;
              timer   <= '0;
              pll_rst <= 1'b1;
            end else timer <= timer + 1'b1;
          SETTLE:
            if (!locked_s) begin
              st    <= WAIT_LOCK;
              timer <= '0;
            end else if (timer == T_LOCK) begin
              st      <= RUN;
              timer   <= '0;
              sys_rst <= 1'b0;
              ready   <= 1'b1;
            end else timer <= timer + 1'b1;
          RUN:
            if (!locked_s) begin
              st      <= RESET_PLL;
              timer   <= '0;
              pll_rst <= 1'b1;
              sys_rst <= 1'b1;
              ready   <= 1'b0;
            end
        endcase
      end
    end
  end
endmodule
